// File: rtl/imem_load_ctrl_pkg.sv
// imem_load_ctrl_pkg
// Shared definitions for the instruction-memory boot loader and fetch
// sequencer: FSM state encoding, word-alignment mask and PC step size.
package imem_load_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    // Low address bits that must be zero for a word-aligned byte address.
    localparam logic [31:0] WORD_ALIGN_MASK = 32'h0000_0003;

    // Sequential fetch advance, in bytes.
    localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/imem_load_port.sv
// imem_load_port
// Program load port. Holds the write pointer, turns accepted load beats into
// instruction-memory write strobes, and flags the end of the program
// (explicit last beat or memory full) together with the program length.
//
// Handshake: a beat transfers on a rising edge where load_valid_i and
// load_ready_o are both high; load_ready_o does not depend on load_valid_i.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   active_i          controller is in the load phase
//   clr_i             restart the program at word 0 (reload)
//   load_valid_i      loader presents a word
//   load_data_i       instruction word
//   load_last_i       final word of the program
//   load_ready_o      beat may be accepted
//   mem_we_o          write enable, same cycle as the accepted beat
//   mem_waddr_o       word write address
//   mem_wdata_o       write data
//   load_done_o       this accepted beat ends the program
//   prog_len_o        number of words in the last completed load
module imem_load_port #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              active_i,
    input  logic              clr_i,
    input  logic              load_valid_i,
    input  logic [31:0]       load_data_i,
    input  logic              load_last_i,
    output logic              load_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [31:0]       mem_wdata_o,
    output logic              load_done_o,
    output logic [ADDR_W:0]   prog_len_o
);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   prog_len_q, prog_len_d;
    logic              accept;
    logic              full;

    assign load_ready_o = active_i;
    assign accept       = active_i & load_valid_i;
    // The last physical word ends the program even without load_last.
    assign full         = (wr_ptr_q == ADDR_W'(DEPTH - 1));
    assign load_done_o  = accept & (load_last_i | full);

    assign mem_we_o     = accept;
    assign mem_waddr_o  = wr_ptr_q;
    assign mem_wdata_o  = load_data_i;
    assign prog_len_o   = prog_len_q;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        prog_len_d = prog_len_q;
        if (clr_i) begin
            wr_ptr_d = '0;
        end else if (accept) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (load_done_o) begin
            prog_len_d = {1'b0, wr_ptr_q} + {{ADDR_W{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            prog_len_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            prog_len_q <= prog_len_d;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// imem_load_ctrl
// Boot-load and fetch sequencer. After reset it writes a program into the
// instruction memory through imem_load_port, then runs the core and owns the
// program counter (sequential +4 or branch redirect). Fetch halts when the
// next PC leaves the loaded region or a misaligned branch target is taken.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   load_valid/ready/data/last    program load handshake
//   mem_we/waddr/wdata            instruction memory write port
//   branch_taken, branch_target   PC redirect request from the core
//   reload                        return to program load from RUN/HALT
//   pc                            current fetch byte address
//   cpu_run                       core may commit the instruction at pc
//   halted, fault                 fetch stopped / stopped on misalignment
//   prog_len                      number of words loaded
//   dbg_state                     FSM state, for observation only
module imem_load_ctrl
    import imem_load_ctrl_pkg::*;
#(
    parameter int          DEPTH    = 32,
    parameter int          ADDR_W   = 5,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [31:0]       load_data,
    input  logic              load_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    input  logic              branch_taken,
    input  logic [31:0]       branch_target,
    input  logic              reload,
    output logic [31:0]       pc,
    output logic              cpu_run,
    output logic              halted,
    output logic              fault,
    output logic [ADDR_W:0]   prog_len,
    output state_e            dbg_state
);

    state_e      state_q;
    logic [31:0] pc_q;
    logic        fault_q;
    logic        halted_q;

    logic        load_done;
    logic        do_reload;
    logic [31:0] pc_nxt;
    logic [29:0] len_words;
    logic        pc_in_range;
    logic        nxt_in_range;
    logic        misaligned;

    imem_load_port #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_load_port (
        .clk          (clk),
        .rst_n        (rst_n),
        .active_i     (state_q == ST_LOAD),
        .clr_i        (do_reload),
        .load_valid_i (load_valid),
        .load_data_i  (load_data),
        .load_last_i  (load_last),
        .load_ready_o (load_ready),
        .mem_we_o     (mem_we),
        .mem_waddr_o  (mem_waddr),
        .mem_wdata_o  (mem_wdata),
        .load_done_o  (load_done),
        .prog_len_o   (prog_len)
    );

    // reload is only meaningful once a program has been loaded.
    assign do_reload    = reload && (state_q != ST_LOAD);

    assign pc_nxt       = branch_taken ? branch_target : (pc_q + PC_STEP);
    assign len_words    = 30'(prog_len);
    assign pc_in_range  = (pc_q[31:2] < len_words);
    assign nxt_in_range = (pc_nxt[31:2] < len_words);
    assign misaligned   = branch_taken && ((branch_target & WORD_ALIGN_MASK) != 32'd0);

    assign pc        = pc_q;
    assign fault     = fault_q;
    assign halted    = halted_q;
    // Suppressed when a RESET_PC outside the program is detected on entry.
    assign cpu_run   = (state_q == ST_RUN) && pc_in_range;
    assign dbg_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_LOAD;
            pc_q     <= RESET_PC;
            fault_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (load_done) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (do_reload) begin
                        state_q  <= ST_LOAD;
                        pc_q     <= RESET_PC;
                        fault_q  <= 1'b0;
                        halted_q <= 1'b0;
                    end else if (misaligned) begin
                        state_q  <= ST_HALT;
                        fault_q  <= 1'b1;
                        halted_q <= 1'b1;
                    end else if (!pc_in_range || !nxt_in_range) begin
                        // Current instruction commits; pc stays on it.
                        state_q  <= ST_HALT;
                        halted_q <= 1'b1;
                    end else begin
                        pc_q <= pc_nxt;
                    end
                end
                ST_HALT: begin
                    if (do_reload) begin
                        state_q  <= ST_LOAD;
                        pc_q     <= RESET_PC;
                        fault_q  <= 1'b0;
                        halted_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: doc/imem_load_ctrl.md
# imem_load_ctrl

Boot-load and fetch sequencer for the single-cycle core's word-addressed instruction memory. After reset it accepts a program over a valid/ready load port and writes it into instruction memory. It then releases the core and owns the program counter: sequential +4 or branch redirect. It halts cleanly when fetch leaves the loaded region or a misaligned target is taken.

## Interface
- DEPTH, 32, instruction memory depth in 32-bit words
- ADDR_W, 5, word-address width (clog2(DEPTH))
- RESET_PC, 32'h0000_0000, byte address of the first fetched instruction; must be word-aligned and below DEPTH*4
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- load_valid  in  1  loader presents a word
- load_ready  out  1  controller accepts the word
- load_data  in  32  instruction word
- load_last  in  1  marks the final word of the program
- mem_we  out  1  instruction memory write enable
- mem_waddr  out  ADDR_W  word write address
- mem_wdata  out  32  write data (= load_data)
- branch_taken  in  1  core requests a PC redirect this cycle
- branch_target  in  32  redirect byte address
- reload  in  1  request to re-enter program load
- pc  out  32  current fetch byte address
- cpu_run  out  1  core may execute/commit the instruction at pc
- halted  out  1  fetch stopped
- fault  out  1  halt caused by a misaligned branch target
- prog_len  out  ADDR_W+1  number of words loaded

## Operation
- States: LOAD, RUN, HALT. Reset enters LOAD.
- LOAD:
  - load_ready=1.
  - A beat is accepted when load_valid&load_ready. It drives mem_we=1, mem_waddr=wr_ptr, mem_wdata=load_data, then wr_ptr++.
  - An accepted beat with load_last=1, or with wr_ptr==DEPTH-1, sets prog_len=wr_ptr+1 and moves to RUN. Memory full forces the end of the program even if load_last=0.
  - pc holds RESET_PC.
- RUN:
  - cpu_run=1.
  - pc_nxt = branch_taken ? branch_target : pc+4.
  - If branch_taken and branch_target[1:0]!=0: set fault=1, go to HALT, pc holds.
  - Else if pc_nxt[31:2] >= prog_len: go to HALT, pc holds. The instruction at the current pc still commits.
  - Else pc<=pc_nxt.
  - Arithmetic is 32-bit unsigned. A wrap of pc+4 past 2^32 yields a small value; that value is range-checked like any other.
- HALT: cpu_run=0, halted=1, pc frozen. load_ready=0.
- reload: in RUN or HALT, go to LOAD next cycle with pc=RESET_PC, wr_ptr=0, fault=0, halted=0. reload has priority over branch and halt detection in the same cycle. reload is ignored while in LOAD.
- If RESET_PC[31:2] >= prog_len on entry to RUN, the first RUN cycle detects it and halts (cpu_run=1 for that cycle is suppressed: cpu_run = RUN && pc in range).

## Timing
- Reset values: state=LOAD, pc=RESET_PC, wr_ptr=0, prog_len=0, load_ready=1, mem_we=0, cpu_run=0, halted=0, fault=0.
- mem_we, mem_waddr and mem_wdata are combinational from the accepted beat, so the write lands on the same edge that accepts it.
- The last beat is accepted at edge N; RUN and cpu_run=1 hold from edge N onward; the first fetch is RESET_PC.
- pc is registered with one-cycle redirect latency: a branch seen in cycle k yields pc=branch_target after edge k.
- Halt detection takes effect at the next edge: halted=1 and cpu_run=0 from that edge.
- Reset asserted mid-load or mid-run returns immediately to reset values. prog_len is lost, and memory contents are undefined from the controller's view.

## Structure
- Shared package: state encoding (LOAD=2'd0, RUN=2'd1, HALT=2'd2), the word-alignment mask, and a PC_STEP=4 constant.
- One natural sub-module: imem_load_port, which holds wr_ptr, produces the write strobes and generates the end-of-load and prog_len outputs. The FSM and PC register stay in the top module.

## Test plan
- Load 4 words (0x00000013, 0x8CDEFAB7, 0x0064A423, 0x0062E233), last on word 4 -> 4 writes at waddr 0..3, prog_len=4, then pc steps 0,4,8,12, then halted=1 with pc=12.
- Load 32 words with load_last=0 throughout -> RUN entered after word 32 (waddr 31), prog_len=32, load_ready=0.
- Stall load_valid for random gaps -> no writes during gaps, addresses contiguous, content matches the sequence.
- In RUN at pc=8, branch_taken with target 0x4 -> pc=4 next cycle; a target of 0x6 -> fault=1, halted=1, pc stays 8.
- Branch to 0x10 with prog_len=4 -> halt; the instruction at the branching pc commits, and pc does not advance.
- reload and branch_taken in the same cycle -> LOAD, pc=RESET_PC, fault cleared. Reset mid-load after 2 beats -> all outputs at their reset values and wr_ptr=0.
